// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART byte receiver.
//   state_t       FSM state encoding (3-bit)
//   DEFAULT_DIV   clocks per bit when the requested divisor is 0
//   MIN_DIV       smallest divisor the receiver will run at
//   FRAME_BITS    start + 8 data + stop
//   eff_div()     maps a requested divisor to the one actually used
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_HIGH = 3'd4
    } state_t;

    localparam logic [15:0] DEFAULT_DIV = 16'd186;
    localparam logic [15:0] MIN_DIV     = 16'd8;
    localparam int          FRAME_BITS  = 10;

    // Index of the last data bit (frame minus start and stop, minus one).
    localparam logic [2:0]  LAST_DATA_BIT = 3'(FRAME_BITS - 3);

    function automatic logic [15:0] eff_div(input logic [15:0] req);
        logic [15:0] d;
        d = req;
        if (req == 16'd0)
            d = DEFAULT_DIV;
        else if (req < MIN_DIV)
            d = MIN_DIV;
        return d;
    endfunction

endpackage

// File: rtl/uart_bit_sampler.sv
// uart_bit_sampler: three-point majority vote around the middle of a bit.
//   clk             system clock
//   i_rxs           synchronised serial line
//   i_cnt           bit timer of the owning FSM
//   i_half          half of the current bit period
//   o_bit           majority of the samples at half-1, half, half+1
//   o_sample_done   high while i_cnt == half+1 (o_bit valid in that cycle)
module uart_bit_sampler (
    input  logic        clk,
    input  logic        i_rxs,
    input  logic [15:0] i_cnt,
    input  logic [15:0] i_half,
    output logic        o_bit,
    output logic        o_sample_done
);

    logic r_s0;
    logic r_s1;

    always_ff @(posedge clk) begin
        if (i_cnt == i_half - 16'd1)
            r_s0 <= i_rxs;
        if (i_cnt == i_half)
            r_s1 <= i_rxs;
    end

    // The third sample is the live line value, so the vote is ready
    // in the same cycle it is taken.
    assign o_sample_done = (i_cnt == i_half + 16'd1);
    assign o_bit = (r_s0 & r_s1) | (r_s0 & i_rxs) | (r_s1 & i_rxs);

endmodule

// File: rtl/uart_byte_rx.sv
// uart_byte_rx: 8N1 UART receiver feeding the game loader byte stream.
//   clk            system clock
//   reset          synchronous, active-high
//   rx_i           asynchronous UART line, idle high
//   baud_div_i     clocks per bit (0 = DEFAULT_DIV, small values clamp to MIN_DIV)
//   data_o         last good byte, held until the next good byte
//   data_valid_o   one-cycle strobe per good byte
//   frame_err_o    one-cycle strobe when a stop bit is sampled low
//   err_count_o    framing errors since reset, saturating at 255
//   byte_count_o   good bytes since reset, wrapping
//   busy_o         high whenever the FSM is not idle
module uart_byte_rx
    import uart_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_i,
    input  logic [15:0] baud_div_i,
    output logic [7:0]  data_o,
    output logic        data_valid_o,
    output logic        frame_err_o,
    output logic [7:0]  err_count_o,
    output logic [21:0] byte_count_o,
    output logic        busy_o
);

    state_t      r_state;
    logic        r_sync1;
    logic        r_rxs;
    logic        r_rxs_prev;
    logic [15:0] r_div;
    logic [15:0] r_cnt;
    logic [2:0]  r_bit_idx;
    logic [7:0]  r_shift;
    logic [7:0]  r_data;
    logic        r_data_valid;
    logic        r_frame_err;
    logic [7:0]  r_err_count;
    logic [21:0] r_byte_count;

    logic [15:0] w_half;
    logic        w_bit;
    logic        w_sample_done;

    assign w_half = {1'b0, r_div[15:1]};

    // Two-flop synchroniser plus one more stage for falling-edge detection.
    // Flops preset high so reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1    <= 1'b1;
            r_rxs      <= 1'b1;
            r_rxs_prev <= 1'b1;
        end else begin
            r_sync1    <= rx_i;
            r_rxs      <= r_sync1;
            r_rxs_prev <= r_rxs;
        end
    end

    uart_bit_sampler u_sampler (
        .clk           (clk),
        .i_rxs         (r_rxs),
        .i_cnt         (r_cnt),
        .i_half        (w_half),
        .o_bit         (w_bit),
        .o_sample_done (w_sample_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_cnt        <= 16'd0;
            r_bit_idx    <= 3'd0;
            r_data       <= 8'd0;
            r_data_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            r_err_count  <= 8'd0;
            r_byte_count <= 22'd0;
        end else begin
            r_data_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            r_cnt        <= r_cnt + 16'd1;
            case (r_state)
                ST_IDLE: begin
                    r_cnt <= 16'd0;
                    if (r_rxs_prev && !r_rxs) begin
                        // Divisor is frozen for the whole frame from here.
                        r_div   <= eff_div(baud_div_i);
                        r_state <= ST_START;
                    end
                end
                ST_START: begin
                    if (w_sample_done && w_bit) begin
                        // Start bit did not survive to mid-bit: glitch.
                        r_state <= ST_IDLE;
                        r_cnt   <= 16'd0;
                    end else if (r_cnt == r_div - 16'd1) begin
                        r_state   <= ST_DATA;
                        r_cnt     <= 16'd0;
                        r_bit_idx <= 3'd0;
                    end
                end
                ST_DATA: begin
                    if (w_sample_done)
                        r_shift <= {w_bit, r_shift[7:1]};
                    if (r_cnt == r_div - 16'd1) begin
                        r_cnt <= 16'd0;
                        if (r_bit_idx == LAST_DATA_BIT)
                            r_state <= ST_STOP;
                        else
                            r_bit_idx <= r_bit_idx + 3'd1;
                    end
                end
                ST_STOP: begin
                    // Leave at mid-stop so a following start edge is not missed.
                    if (w_sample_done) begin
                        r_cnt <= 16'd0;
                        if (w_bit) begin
                            r_data       <= r_shift;
                            r_data_valid <= 1'b1;
                            r_byte_count <= r_byte_count + 22'd1;
                            r_state      <= ST_IDLE;
                        end else begin
                            r_frame_err <= 1'b1;
                            if (r_err_count != 8'hFF)
                                r_err_count <= r_err_count + 8'd1;
                            r_state <= ST_WAIT_HIGH;
                        end
                    end
                end
                ST_WAIT_HIGH: begin
                    // r_cnt counts consecutive high cycles; a held-low break
                    // stays here and produces only the one error.
                    if (!r_rxs)
                        r_cnt <= 16'd0;
                    else if (r_cnt == w_half - 16'd1) begin
                        r_cnt   <= 16'd0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= 16'd0;
                end
            endcase
        end
    end

    assign data_o       = r_data;
    assign data_valid_o = r_data_valid;
    assign frame_err_o  = r_frame_err;
    assign err_count_o  = r_err_count;
    assign byte_count_o = r_byte_count;
    assign busy_o       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_byte_rx.sv
// tb_uart_byte_rx: scoreboard bench for uart_byte_rx.
module tb_uart_byte_rx;

    logic        clk;
    logic        reset;
    logic        rx_i;
    logic [15:0] baud_div_i;
    logic [7:0]  data_o;
    logic        data_valid_o;
    logic        frame_err_o;
    logic [7:0]  err_count_o;
    logic [21:0] byte_count_o;
    logic        busy_o;

    uart_byte_rx dut (
        .clk          (clk),
        .reset        (reset),
        .rx_i         (rx_i),
        .baud_div_i   (baud_div_i),
        .data_o       (data_o),
        .data_valid_o (data_valid_o),
        .frame_err_o  (frame_err_o),
        .err_count_o  (err_count_o),
        .byte_count_o (byte_count_o),
        .busy_o       (busy_o)
    );

    typedef struct packed {
        logic       is_err;
        logic [7:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_total = 0;
    int   n_pass  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    // Output monitor: every strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!reset && (data_valid_o || frame_err_o)) begin
            if (data_valid_o && frame_err_o)
                chk("both_strobes", 32'd1, 32'd0);
            if (sb.size() == 0) begin
                chk("unexpected_strobe", {30'd0, data_valid_o, frame_err_o}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("strobe_kind", {31'd0, frame_err_o}, {31'd0, e.is_err});
                if (!e.is_err) begin
                    chk("data", {24'd0, data_o}, {24'd0, e.data});
                    chk("busy_after_stop", {31'd0, busy_o}, 32'd0);
                end
            end
        end
    end

    // All stimulus changes land 1 time unit after a rising edge.
    task automatic drive_bit(input logic b, input int n);
        rx_i = b;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        drive_bit(1'b1, n);
    endtask

    task automatic send_frame(input logic [7:0] d, input int div, input logic stop);
        exp_t e;
        e.is_err = ~stop;
        e.data   = d;
        sb.push_back(e);
        drive_bit(1'b0, div);
        for (int i = 0; i < 8; i++)
            drive_bit(d[i], div);
        drive_bit(stop, div);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(tag, sb.size(), 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        rx_i  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_total);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] t1 [4];
        t1[0] = 8'h4E; t1[1] = 8'h45; t1[2] = 8'h53; t1[3] = 8'h1A;

        baud_div_i = 16'd24;
        do_reset();
        reset = 1'b0;
        @(posedge clk); #1;
        chk("rst_data",   {24'd0, data_o}, 32'd0);
        chk("rst_valid",  {31'd0, data_valid_o}, 32'd0);
        chk("rst_ferr",   {31'd0, frame_err_o}, 32'd0);
        chk("rst_errcnt", {24'd0, err_count_o}, 32'd0);
        chk("rst_bytecnt", {10'd0, byte_count_o}, 32'd0);
        chk("rst_busy",   {31'd0, busy_o}, 32'd0);
        idle(30);

        // Back-to-back frames at div 24
        for (int i = 0; i < 4; i++)
            send_frame(t1[i], 24, 1'b1);
        idle(30);
        drain("t1_drain");
        chk("t1_bytecnt", {10'd0, byte_count_o}, 32'd4);
        chk("t1_errcnt",  {24'd0, err_count_o}, 32'd0);
        chk("t1_busy",    {31'd0, busy_o}, 32'd0);

        // Framing error then recovery
        send_frame(8'hA5, 24, 1'b0);
        idle(24);
        drain("t2_err_drain");
        chk("t2_errcnt",   {24'd0, err_count_o}, 32'd1);
        chk("t2_busy",     {31'd0, busy_o}, 32'd0);
        chk("t2_data_held", {24'd0, data_o}, 32'h1A);
        send_frame(8'h3C, 24, 1'b1);
        idle(30);
        drain("t2_drain");
        chk("t2_bytecnt", {10'd0, byte_count_o}, 32'd5);

        // Glitches on an idle line
        drive_bit(1'b0, 1);
        idle(60);
        drive_bit(1'b0, 8);
        idle(60);
        chk("t3_busy",    {31'd0, busy_o}, 32'd0);
        chk("t3_bytecnt", {10'd0, byte_count_o}, 32'd5);
        chk("t3_errcnt",  {24'd0, err_count_o}, 32'd1);

        // Default divisor and clamped divisor
        baud_div_i = 16'd0;
        send_frame(8'hFF, 186, 1'b1);
        idle(400);
        send_frame(8'h00, 186, 1'b1);
        idle(400);
        baud_div_i = 16'd3;
        send_frame(8'hFF, 8, 1'b1);
        idle(20);
        send_frame(8'h00, 8, 1'b1);
        idle(20);
        drain("t4_drain");
        chk("t4_bytecnt", {10'd0, byte_count_o}, 32'd9);

        // Break: line low for 40 bit periods gives one error
        baud_div_i = 16'd24;
        begin
            exp_t e;
            e.is_err = 1'b1;
            e.data   = 8'h00;
            sb.push_back(e);
        end
        drive_bit(1'b0, 40 * 24);
        idle(48);
        drain("t6_break_drain");
        chk("t6_break_errcnt", {24'd0, err_count_o}, 32'd2);
        chk("t6_break_busy",   {31'd0, busy_o}, 32'd0);

        // Saturation with 300 error frames at div 8
        baud_div_i = 16'd8;
        for (int i = 0; i < 300; i++) begin
            send_frame(8'h00, 8, 1'b0);
            idle(16);
        end
        drain("t6_sat_drain");
        chk("t6_sat_errcnt", {24'd0, err_count_o}, 32'd255);
        chk("t6_sat_bytecnt", {10'd0, byte_count_o}, 32'd9);

        // Reset in the middle of DATA bit 4 of 0x55
        baud_div_i = 16'd24;
        drive_bit(1'b0, 24);
        for (int i = 0; i < 4; i++)
            drive_bit(i[0] ? 1'b0 : 1'b1, 24);
        drive_bit(1'b1, 12);
        chk("t5_busy_pre", {31'd0, busy_o}, 32'd1);
        do_reset();
        chk("t5_rst_data",    {24'd0, data_o}, 32'd0);
        chk("t5_rst_errcnt",  {24'd0, err_count_o}, 32'd0);
        chk("t5_rst_bytecnt", {10'd0, byte_count_o}, 32'd0);
        chk("t5_rst_busy",    {31'd0, busy_o}, 32'd0);
        reset = 1'b0;
        idle(72);
        chk("t5_idle_busy", {31'd0, busy_o}, 32'd0);
        send_frame(8'h12, 24, 1'b1);
        idle(30);
        drain("t5_drain");
        chk("t5_bytecnt", {10'd0, byte_count_o}, 32'd1);
        chk("t5_data",    {24'd0, data_o}, 32'h12);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
